// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO between the UART receiver stage and the bus.
// Each entry keeps the receiver error bit alongside the character.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_ready,
   input  logic                      rx_error,
   input  logic                      rd_en,
   input  logic                      clr_flags,
   input  logic [$clog2(DEPTH):0]    thresh,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_perr,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   output logic                      frame_err,
   output logic                      thresh_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [DATA_WIDTH:0] head;
   logic [LW-1:0]       level_nxt;
   logic                do_pop;
   logic                do_push;
   logic                ovf_set;
   logic                fe_set;

   assign do_pop  = rd_en && !empty;
   assign do_push = rx_ready && (!full || do_pop);
   assign ovf_set = rx_ready && full && !do_pop;
   assign fe_set  = rx_error && !rx_ready;

   always_comb begin
      level_nxt = level;
      if (do_push && !do_pop)
         level_nxt = level + 1'b1;
      else if (do_pop && !do_push)
         level_nxt = level - 1'b1;
   end

   // Storage is not reset; empty masks stale contents on the read side.
   always_ff @(posedge clk) begin
      if (rst_n && do_push)
         mem[wr_ptr] <= {rx_error, rx_data};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         empty <= (level_nxt == '0);
         full  <= (level_nxt == FULL_LVL);
         if (ovf_set)
            overflow <= 1'b1;
         else if (clr_flags)
            overflow <= 1'b0;
         if (fe_set)
            frame_err <= 1'b1;
         else if (clr_flags)
            frame_err <= 1'b0;
      end
   end

   assign head       = mem[rd_ptr];
   assign rd_data    = empty ? '0 : head[DATA_WIDTH-1:0];
   assign rd_perr    = empty ? 1'b0 : head[DATA_WIDTH];
   assign thresh_irq = (thresh != '0) && (level >= thresh);

endmodule
